// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// cpu_mem_pkg : shared constants and types for the CPU data-memory responder
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

  // MMIO occupies the top words of the data address space.
  localparam int unsigned MMIO_WINDOW = 8;

  // Word offsets inside the MMIO window
  localparam logic [2:0] MMIO_GPIO_OUT = 3'd0;
  localparam logic [2:0] MMIO_GPIO_IN  = 3'd1;
  localparam logic [2:0] MMIO_TMR_LO   = 3'd2;
  localparam logic [2:0] MMIO_TMR_HI   = 3'd3;
  localparam logic [2:0] MMIO_CTRL     = 3'd4;
  localparam logic [2:0] MMIO_PRESCALE = 3'd5;

  // CTRL register bit positions
  localparam int unsigned CTRL_RUN   = 0;
  localparam int unsigned CTRL_CLEAR = 1;
  localparam int unsigned CTRL_WRAP  = 2;
  localparam int unsigned CTRL_SNAP  = 3;

  // Decoded view of the low nibble of a CTRL write
  typedef struct packed {
    logic snap;
    logic wrap_clr;
    logic clear;
    logic run;
  } ctrl_wr_t;

  function automatic ctrl_wr_t decode_ctrl(input logic [7:0] wdata);
    ctrl_wr_t c;
    c.run      = wdata[CTRL_RUN];
    c.clear    = wdata[CTRL_CLEAR];
    c.wrap_clr = wdata[CTRL_WRAP];
    c.snap     = wdata[CTRL_SNAP];
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// mmio_timer : prescaled 16-bit timer with snapshot register and sticky wrap
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mmio_timer
  import cpu_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_we,
  input  ctrl_wr_t    ctrl_wr,
  input  logic        prescale_we,
  input  logic [7:0]  prescale_wdata,
  output logic        run,
  output logic        wrap,
  output logic [15:0] snapshot,
  output logic [7:0]  prescale
);

  logic [15:0] timer;
  logic [7:0]  pcnt;
  logic        tick;
  logic        clear;
  logic        snap;
  logic        wrap_clr;
  logic        wrap_set;

  assign tick     = run && (pcnt == prescale);
  assign clear    = ctrl_we && ctrl_wr.clear;
  assign snap     = ctrl_we && ctrl_wr.snap;
  assign wrap_clr = ctrl_we && ctrl_wr.wrap_clr;
  // A clear suppresses the increment, so it also suppresses the wrap it would cause.
  assign wrap_set = tick && !clear && (timer == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      wrap     <= 1'b0;
      snapshot <= 16'h0000;
      prescale <= 8'h00;
      timer    <= 16'h0000;
      pcnt     <= 8'h00;
    end else begin
      if (ctrl_we)
        run <= ctrl_wr.run;
      if (prescale_we)
        prescale <= prescale_wdata;
      // Snapshot sees the value before any clear in the same write.
      if (snap)
        snapshot <= timer;

      if (clear) begin
        timer <= 16'h0000;
        pcnt  <= 8'h00;
      end else begin
        if (tick)
          timer <= timer + 16'd1;
        if (prescale_we)
          pcnt <= 8'h00;
        else if (run)
          pcnt <= tick ? 8'h00 : pcnt + 8'd1;
      end

      if (wrap_set)
        wrap <= 1'b1;
      else if (wrap_clr)
        wrap <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// ============================================================================
// ram_responder : CPU data-memory target with combinational reads, registered
//                 writes and an MMIO window for GPIO and a timer
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ram_responder
  import cpu_mem_pkg::*;
#(
  parameter int g_RAM_WIDTH = 9,
  parameter int g_RAM_ADDR  = 11,
  parameter int g_MMIO_EN   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ram_en,
  input  logic                   i_ram_we,
  input  logic                   i_ram_re,
  input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
  input  logic [g_RAM_WIDTH-1:0] i_ram_data,
  output logic [g_RAM_WIDTH-1:0] o_ram_data,
  input  logic [7:0]             i_gpio,
  output logic [7:0]             o_gpio,
  output logic                   o_timer_wrap
);

  localparam int unsigned DEPTH = (g_MMIO_EN != 0) ? (2**g_RAM_ADDR - MMIO_WINDOW)
                                                   : (2**g_RAM_ADDR);
  localparam logic [g_RAM_ADDR-1:0] WIN_BASE = g_RAM_ADDR'(2**g_RAM_ADDR - MMIO_WINDOW);
  localparam int unsigned PAD = g_RAM_WIDTH - 8;

  logic [g_RAM_WIDTH-1:0] mem [DEPTH];

  logic        in_win;
  logic [2:0]  offset;
  logic        wr;
  logic        ram_wr;
  logic        mmio_wr;
  logic [7:0]  wbyte;
  logic [7:0]  gpio_s1;
  logic [7:0]  gpio_s2;
  logic [7:0]  mmio_rd;

  logic        tmr_run;
  logic        tmr_wrap;
  logic [15:0] tmr_snap;
  logic [7:0]  tmr_prescale;

  assign in_win  = (g_MMIO_EN != 0) && (i_ram_addr >= WIN_BASE);
  assign offset  = i_ram_addr[2:0];
  assign wr      = i_ram_en && i_ram_we;
  assign ram_wr  = wr && !in_win;
  assign mmio_wr = wr && in_win;
  assign wbyte   = i_ram_data[7:0];

  // Array is deliberately not reset; a write coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && ram_wr)
      mem[i_ram_addr] <= i_ram_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gpio  <= 8'h00;
      gpio_s1 <= 8'h00;
      gpio_s2 <= 8'h00;
    end else begin
      gpio_s1 <= i_gpio;
      gpio_s2 <= gpio_s1;
      if (mmio_wr && (offset == MMIO_GPIO_OUT))
        o_gpio <= wbyte;
    end
  end

  mmio_timer u_timer (
    .clk            (i_clk),
    .rst_n          (i_rst_n),
    .ctrl_we        (mmio_wr && (offset == MMIO_CTRL)),
    .ctrl_wr        (decode_ctrl(wbyte)),
    .prescale_we    (mmio_wr && (offset == MMIO_PRESCALE)),
    .prescale_wdata (wbyte),
    .run            (tmr_run),
    .wrap           (tmr_wrap),
    .snapshot       (tmr_snap),
    .prescale       (tmr_prescale)
  );

  assign o_timer_wrap = tmr_wrap;

  always_comb begin
    mmio_rd = 8'h00;
    case (offset)
      MMIO_GPIO_OUT: mmio_rd = o_gpio;
      MMIO_GPIO_IN:  mmio_rd = gpio_s2;
      MMIO_TMR_LO:   mmio_rd = tmr_snap[7:0];
      MMIO_TMR_HI:   mmio_rd = tmr_snap[15:8];
      MMIO_CTRL:     mmio_rd = {5'b00000, tmr_wrap, 1'b0, tmr_run};
      MMIO_PRESCALE: mmio_rd = tmr_prescale;
      default:       mmio_rd = 8'h00;
    endcase
  end

  // Zero-latency read: the CPU samples this on the same edge as the load.
  always_comb begin
    o_ram_data = '0;
    if (i_ram_en && i_ram_re) begin
      if (in_win)
        o_ram_data = {{PAD{1'b0}}, mmio_rd};
      else
        o_ram_data = mem[i_ram_addr];
    end
  end

endmodule

`default_nettype wire

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Data-memory responder on the CPU's RAM port; it is the target end of the en/we/re/addr/data interface the CPU drives.
- Serves LDR with combinational read data and STR with single-cycle registered writes.
- Decodes the top 8 words of the address space as MMIO: GPIO out/in, a prescaled 16-bit timer with snapshot, and a sticky wrap flag.
- Sits beside the CPU in the top level, replacing a bare RAM.

Parameters:
- g_RAM_WIDTH, 9, data word width; MMIO uses bits [7:0], bit 8 reads as 0.
- g_RAM_ADDR, 11, address width. Array depth is 2^g_RAM_ADDR - 8 words.
- g_MMIO_EN, 1, 1 decodes the MMIO window. 0 makes the full address space RAM.

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_ram_en  in  1  access enable from CPU
- i_ram_we  in  1  write strobe; a write occurs at the rising edge when en=1 and we=1
- i_ram_re  in  1  read qualifier (CPU drives it as !we)
- i_ram_addr  in  g_RAM_ADDR  word address
- i_ram_data  in  g_RAM_WIDTH  write data
- o_ram_data  out  g_RAM_WIDTH  read data, combinational from addr
- i_gpio  in  8  asynchronous inputs
- o_gpio  out  8  GPIO output register
- o_timer_wrap  out  1  sticky wrap flag (mirror of CTRL bit2)

Behaviour:
- Reset: asynchronous and active-low; it takes effect immediately.
  - o_gpio=0, timer=0, snapshot=0, prescale=0, prescale counter=0, CTRL=0, o_timer_wrap=0, GPIO synchronizer flops=0.
  - The RAM array is not reset; its contents are undefined.
  - A write in progress when reset asserts is dropped.
- Read path:
  - o_ram_data = decode(addr) when en=1 and re=1, else 0.
  - Fully combinational, zero latency. The CPU samples it on the same edge as LDR, so no synchronous RAM is allowed.
- Write path: when en=1 and we=1, the target is updated at the rising edge. Data and address are those present during that cycle.
- MMIO window: active when g_MMIO_EN=1 and addr >= 2^g_RAM_ADDR-8. Offsets:
  - +0 GPIO_OUT: RW, drives o_gpio.
  - +1 GPIO_IN: RO, i_gpio after a 2-flop synchronizer, so it is 2 cycles stale.
  - +2 TMR_LO: RO, snapshot[7:0].
  - +3 TMR_HI: RO, snapshot[15:8].
  - +4 CTRL: bit0 run (RW); bit1 clear (W1, self-clearing, zeroes the timer and prescale counter); bit2 wrap (sticky, write 1 clears); bit3 snap (W1, copies the timer into the snapshot; self-clearing).
  - +5 PRESCALE: RW; writing it also zeroes the prescale counter.
  - +6, +7: read 0, writes ignored.
- RAM accesses outside the window go to the array. MMIO writes ignore i_ram_data[8].
- Timer: runs only when run=1.
  - The prescale counter counts 0..PRESCALE; the timer increments when it equals PRESCALE, then the prescale counter returns to 0.
  - PRESCALE=0 means the timer increments every cycle.
  - On a 0xFFFF->0x0000 increment, wrap is set.
- Simultaneous events:
  - wrap set and a W1-clear in the same cycle: set wins.
  - clear and snap in the same write: the snapshot takes the pre-clear value.
  - clear while run=1: the timer is 0 on the next cycle and resumes counting from there.
- CTRL reads return {0, 0, 0, 0, 0, wrap, 0, run}; bits 1 and 3 always read as 0.

Decomposition:
- Shared package, cpu_mem_pkg:
  - MMIO offset constants: MMIO_GPIO_OUT=0, MMIO_GPIO_IN=1, MMIO_TMR_LO=2, MMIO_TMR_HI=3, MMIO_CTRL=4, MMIO_PRESCALE=5.
  - CTRL bit index constants.
  - MMIO_WINDOW=8.
- Sub-module mmio_timer: holds the prescaler, 16-bit counter, snapshot and wrap flag. ram_responder keeps the array, address decode, GPIO and read mux.

Test Plan:
- RAM write/read: write 0x1A5 to addr 0x005, then read 0x005. Expect o_ram_data=0x1A5 combinationally. With en=0, the same read gives 0.
- GPIO: write 0x3C to 0x7F8, expect o_gpio=0x3C after the edge. Drive i_gpio=0x81, expect reading 0x7F9 to give 0x081 from the 2nd edge onward.
- Timer prescale: write PRESCALE=3, then CTRL=0x01, run for 40 cycles, then write CTRL=0x09 and read 0x7FA. Expect 10 (±1 relative to the write edge) and 0x7FB=0.
- Timer wrap: preload by counting with PRESCALE=0 for 65536 cycles. Expect o_timer_wrap=1 and CTRL reads 0x05. Write CTRL=0x05: wrap is cleared and run stays 1. Time the clear to the same cycle as a wrap and expect wrap to stay 1.
- Reset mid-operation: with the timer running, o_gpio=0xFF and we=1, drop i_rst_n mid-cycle. Expect o_gpio=0, the timer and snapshot at 0, and o_timer_wrap=0 immediately, with the pending write not applied.
